wb_dp_ram_burst: RTL and testbench

Single-clock, dual-port Wishbone B3 RAM with parametrised data width and non-power-of-two depth. It supports byte-lane writes, linear incrementing bursts (CTI 3'b010) at one beat per clock, and bus-error signalling for out-of-range words. It is the next-generation on-chip memory behind the CPU instruction/data buses and the DMA/peripheral master, replacing stall-based range checking with proper ERR termination.

---
 rtl/wb_dp_ram_burst.sv | 232 +++++++++++++++++++++++
 tb/tb_wb_dp_ram_burst.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_dp_ram_burst.sv
// wb_dp_ram_burst: single-clock dual-port Wishbone B3 RAM with byte lanes, incrementing
// bursts (CTI 010) at one beat per clock, and ERR termination for out-of-range words.
//
// Ports (X = a or b, two identical independent ports):
//   clk_i          clock shared by both ports
//   rst_i          synchronous active-high reset (FSMs and outputs only, memory kept)
//   X_adr_i        byte address, low $clog2(SELECT_WIDTH) bits ignored
//   X_dat_i        write data
//   X_dat_o        registered read data
//   X_we_i         write enable
//   X_sel_i        byte lane select
//   X_stb_i        strobe
//   X_cyc_i        cycle
//   X_cti_i        cycle type: 000 classic, 010 incrementing burst, 111 end of burst
//   X_ack_o        registered acknowledge
//   X_err_o        registered bus error
module wb_dp_ram_burst #(
    parameter int    DATA_WIDTH   = 32,
    parameter int    SELECT_WIDTH = DATA_WIDTH / 8,
    parameter int    DEPTH        = 1024,
    parameter int    ADDR_WIDTH   = $clog2(DEPTH * SELECT_WIDTH),
    parameter int    LOAD_IMAGE   = 0,
    parameter string IMAGE_FILE   = "@IMAGE@"
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic [ADDR_WIDTH-1:0]   a_adr_i,
    input  logic [DATA_WIDTH-1:0]   a_dat_i,
    output logic [DATA_WIDTH-1:0]   a_dat_o,
    input  logic                    a_we_i,
    input  logic [SELECT_WIDTH-1:0] a_sel_i,
    input  logic                    a_stb_i,
    input  logic                    a_cyc_i,
    input  logic [2:0]              a_cti_i,
    output logic                    a_ack_o,
    output logic                    a_err_o,

    input  logic [ADDR_WIDTH-1:0]   b_adr_i,
    input  logic [DATA_WIDTH-1:0]   b_dat_i,
    output logic [DATA_WIDTH-1:0]   b_dat_o,
    input  logic                    b_we_i,
    input  logic [SELECT_WIDTH-1:0] b_sel_i,
    input  logic                    b_stb_i,
    input  logic                    b_cyc_i,
    input  logic [2:0]              b_cti_i,
    output logic                    b_ack_o,
    output logic                    b_err_o
);

    localparam int LSB = $clog2(SELECT_WIDTH);
    localparam int WW  = ADDR_WIDTH - LSB;
    localparam logic [WW:0] DepthW = (WW + 1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StSingle, StBurst} state_e;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Port 0 is A, port 1 is B.
    logic [ADDR_WIDTH-1:0]   adr  [2];
    logic [DATA_WIDTH-1:0]   wdat [2];
    logic [SELECT_WIDTH-1:0] sel  [2];
    logic [2:0]              cti  [2];
    logic                    we   [2];
    logic                    req  [2];

    assign adr[0] = a_adr_i;  assign adr[1] = b_adr_i;
    assign wdat[0] = a_dat_i; assign wdat[1] = b_dat_i;
    assign sel[0] = a_sel_i;  assign sel[1] = b_sel_i;
    assign cti[0] = a_cti_i;  assign cti[1] = b_cti_i;
    assign we[0] = a_we_i;    assign we[1] = b_we_i;
    assign req[0] = a_cyc_i & a_stb_i;
    assign req[1] = b_cyc_i & b_stb_i;

    logic unused_adr;
    assign unused_adr = ^{a_adr_i, b_adr_i};

    state_e                state_q [2], state_d [2];
    logic                  ack_q [2], ack_d [2];
    logic                  err_q [2], err_d [2];
    logic                  first_q [2], first_d [2];
    logic [WW-1:0]         cur_q [2], cur_d [2];
    logic [DATA_WIDTH-1:0] dat_q [2];

    logic [WW-1:0] widx [2];
    logic          in_range [2];
    logic [WW:0]   nxt [2];
    logic          nxt_ok [2];
    logic          beat [2];
    logic          wr_en [2], rd_en [2], fwd [2];
    logic [WW-1:0] wr_idx [2], rd_idx [2];

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            widx[p]     = adr[p][ADDR_WIDTH-1:LSB];
            in_range[p] = {1'b0, widx[p]} < DepthW;
            nxt[p]      = {1'b0, cur_q[p]} + (WW + 1)'(1);
            nxt_ok[p]   = nxt[p] < DepthW;
            // In StBurst ack is always high, so this marks a completed beat.
            beat[p]     = ack_q[p] & req[p];
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < 2; p++) begin
            if (rst_i) state_q[p] <= StIdle;
            else       state_q[p] <= state_d[p];
        end
    end

    // Next-state logic.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            state_d[p] = state_q[p];
            unique case (state_q[p])
                StIdle: begin
                    // A pending error pulse blocks acceptance for its cycle.
                    if (req[p] && !err_q[p] && in_range[p]) begin
                        state_d[p] = (cti[p] == 3'b010) ? StBurst : StSingle;
                    end
                end
                StSingle: state_d[p] = StIdle;
                StBurst: begin
                    if (!beat[p] || cti[p] != 3'b010 || !nxt_ok[p]) state_d[p] = StIdle;
                end
                default: state_d[p] = StIdle;
            endcase
        end
    end

    // Output / datapath control.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            ack_d[p]   = 1'b0;
            err_d[p]   = 1'b0;
            first_d[p] = 1'b0;
            cur_d[p]   = cur_q[p];
            wr_en[p]   = 1'b0;
            wr_idx[p]  = cur_q[p];
            rd_en[p]   = 1'b0;
            rd_idx[p]  = cur_q[p];
            fwd[p]     = 1'b0;
            unique case (state_q[p])
                StIdle: begin
                    if (req[p] && !err_q[p]) begin
                        if (in_range[p]) begin
                            ack_d[p]   = 1'b1;
                            first_d[p] = 1'b1;
                            cur_d[p]   = widx[p];
                            wr_en[p]   = we[p];
                            wr_idx[p]  = widx[p];
                            rd_en[p]   = 1'b1;
                            rd_idx[p]  = widx[p];
                            fwd[p]     = we[p];
                        end else begin
                            err_d[p] = 1'b1;
                        end
                    end
                end
                StBurst: begin
                    if (beat[p]) begin
                        // Beat 0 was already written on the accept edge.
                        wr_en[p] = we[p] & ~first_q[p];
                        if (cti[p] == 3'b010) begin
                            if (nxt_ok[p]) begin
                                ack_d[p]  = 1'b1;
                                cur_d[p]  = nxt[p][WW-1:0];
                                rd_en[p]  = 1'b1;
                                rd_idx[p] = nxt[p][WW-1:0];
                            end else begin
                                err_d[p] = 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        for (int p = 0; p < 2; p++) begin
            if (rst_i) begin
                ack_q[p]   <= 1'b0;
                err_q[p]   <= 1'b0;
                first_q[p] <= 1'b0;
                cur_q[p]   <= '0;
            end else begin
                ack_q[p]   <= ack_d[p];
                err_q[p]   <= err_d[p];
                first_q[p] <= first_d[p];
                cur_q[p]   <= cur_d[p];
            end
        end
    end

    // B is written first so that A's lanes win on a same-word collision.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int p = 1; p >= 0; p--) begin
                if (wr_en[p]) begin
                    for (int i = 0; i < SELECT_WIDTH; i++) begin
                        if (sel[p][i]) mem[wr_idx[p]][8*i +: 8] <= wdat[p][8*i +: 8];
                    end
                end
            end
        end
    end

    // Read-first across ports; own-port written lanes are forwarded on the accept edge.
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < 2; p++) begin
            if (rst_i) begin
                dat_q[p] <= '0;
            end else if (rd_en[p]) begin
                for (int i = 0; i < SELECT_WIDTH; i++) begin
                    dat_q[p][8*i +: 8] <= (fwd[p] && sel[p][i]) ? wdat[p][8*i +: 8]
                                                                : mem[rd_idx[p]][8*i +: 8];
                end
            end
        end
    end

    assign a_ack_o = ack_q[0];
    assign a_err_o = err_q[0];
    assign a_dat_o = dat_q[0];
    assign b_ack_o = ack_q[1];
    assign b_err_o = err_q[1];
    assign b_dat_o = dat_q[1];

endmodule

// File: tb/tb_wb_dp_ram_burst.sv
module tb_wb_dp_ram_burst;

    localparam int DW    = 32;
    localparam int SW    = 4;
    localparam int DEPTH = 1000;
    localparam int AW    = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [AW-1:0] a_adr = '0, b_adr = '0;
    logic [DW-1:0] a_dat = '0, b_dat = '0;
    logic [SW-1:0] a_sel = '0, b_sel = '0;
    logic [2:0]    a_cti = '0, b_cti = '0;
    logic          a_we = 1'b0, b_we = 1'b0;
    logic          a_stb = 1'b0, b_stb = 1'b0;
    logic          a_cyc = 1'b0, b_cyc = 1'b0;
    logic [DW-1:0] a_dat_o, b_dat_o;
    logic          a_ack_o, b_ack_o, a_err_o, b_err_o;

    always #5 clk = ~clk;

    wb_dp_ram_burst #(
        .DATA_WIDTH(DW),
        .SELECT_WIDTH(SW),
        .DEPTH(DEPTH),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .a_adr_i(a_adr), .a_dat_i(a_dat), .a_dat_o(a_dat_o), .a_we_i(a_we), .a_sel_i(a_sel),
        .a_stb_i(a_stb), .a_cyc_i(a_cyc), .a_cti_i(a_cti), .a_ack_o(a_ack_o), .a_err_o(a_err_o),
        .b_adr_i(b_adr), .b_dat_i(b_dat), .b_dat_o(b_dat_o), .b_we_i(b_we), .b_sel_i(b_sel),
        .b_stb_i(b_stb), .b_cyc_i(b_cyc), .b_cti_i(b_cti), .b_ack_o(b_ack_o), .b_err_o(b_err_o)
    );

    typedef struct {
        int          due;
        logic        err;
        logic        chk;
        logic [31:0] dat;
        int          tag;
    } exp_t;

    typedef struct {
        int          p;
        int          adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic        err;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] model [DEPTH];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc_n   = 0;
    int          tag_n   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic logic ack_of(input int p);
        return (p == 0) ? a_ack_o : b_ack_o;
    endfunction

    task automatic push_exp(input int p, input logic err, input logic c, input logic [31:0] d);
        exp_t e;
        e.due = cyc_n + 1;
        e.err = err;
        e.chk = c;
        e.dat = d;
        e.tag = tag_n++;
        if (p == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic mon_port(input int p, input logic ack, input logic err, input logic [31:0] dat);
        exp_t e;
        int   qs;
        string pn;
        pn = (p == 0) ? "A" : "B";
        qs = (p == 0) ? q0.size() : q1.size();
        if (ack || err) begin
            n_tests++;
            if (qs == 0) begin
                n_fail++;
                $display("FAIL port %s unexpected response at cycle %0d: ack=%0b err=%0b, required none",
                         pn, cyc_n, ack, err);
            end else begin
                if (p == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                if (e.due != cyc_n || err !== e.err || ack === e.err || (e.chk && dat !== e.dat)) begin
                    n_fail++;
                    $display("FAIL port %s resp %0d: cycle %0d ack=%0b err=%0b dat=%h, required cycle %0d err=%0b dat=%h",
                             pn, e.tag, cyc_n, ack, err, dat, e.due, e.err, e.dat);
                end
            end
        end else if (qs != 0) begin
            e = (p == 0) ? q0[0] : q1[0];
            if (e.due <= cyc_n) begin
                n_tests++;
                n_fail++;
                if (p == 0) void'(q0.pop_front());
                else        void'(q1.pop_front());
                $display("FAIL port %s resp %0d missing at cycle %0d: got no ack/err, required err=%0b",
                         pn, e.tag, cyc_n, e.err);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc_n++;
        #1;
        mon_port(0, a_ack_o, a_err_o, a_dat_o);
        mon_port(1, b_ack_o, b_err_o, b_dat_o);
    endtask

    task automatic drive(input int p, input int badr, input logic we, input logic [3:0] sel,
                         input logic [31:0] dat, input logic [2:0] cti);
        if (p == 0) begin
            a_cyc = 1'b1; a_stb = 1'b1; a_adr = badr[AW-1:0]; a_we = we;
            a_sel = sel; a_dat = dat; a_cti = cti;
        end else begin
            b_cyc = 1'b1; b_stb = 1'b1; b_adr = badr[AW-1:0]; b_we = we;
            b_sel = sel; b_dat = dat; b_cti = cti;
        end
    endtask

    task automatic idle(input int p);
        if (p == 0) begin a_cyc = 1'b0; a_stb = 1'b0; a_we = 1'b0; a_cti = 3'b000; end
        else        begin b_cyc = 1'b0; b_stb = 1'b0; b_we = 1'b0; b_cti = 3'b000; end
    endtask

    task automatic classic(input vec_t v);
        drive(v.p, v.adr, v.we, v.sel, v.dat, 3'b000);
        push_exp(v.p, v.err, v.chk, v.exp);
        tick();
        idle(v.p);
        tick();
    endtask

    // Beat b carries seed+b; err_beat < 0 means the burst ends normally.
    task automatic burst(input int p, input int base, input logic we, input int n,
                         input int err_beat, input logic [31:0] seed);
        logic [2:0] cti;
        cti = (n == 1) ? 3'b111 : 3'b010;
        drive(p, base * 4, we, 4'hF, seed, cti);
        push_exp(p, 1'b0, 1'b1, we ? seed : model[base]);
        if (we) model[base] = seed;
        tick();
        for (int b = 0; b < n; b++) begin
            if (we && b > 0) model[base + b] = seed + 32'(b);
            if (b + 1 == err_beat)  push_exp(p, 1'b1, 1'b0, '0);
            else if (b + 1 < n)     push_exp(p, 1'b0, !we, we ? 32'h0 : model[base + b + 1]);
            tick();
            if (b + 1 == err_beat) break;
            if (b + 1 < n) begin
                cti = (b + 2 == n) ? 3'b111 : 3'b010;
                drive(p, (base + b + 1) * 4, we, 4'hF, seed + 32'(b + 1), cti);
            end
        end
        idle(p);
        chk("burst end ack low", {63'd0, ack_of(p)}, 64'd0);
        tick();
    endtask

    vec_t vt[13];

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish in time, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //         p  adr     we    sel    dat            err   chk   exp
        vt[0]  = '{0, 'h010, 1'b1, 4'hF, 32'hDEADBEEF, 1'b0, 1'b1, 32'hDEADBEEF};
        vt[1]  = '{0, 'h010, 1'b0, 4'hF, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
        vt[2]  = '{0, 'h040, 1'b1, 4'hF, 32'hAABBCCDD, 1'b0, 1'b1, 32'hAABBCCDD};
        vt[3]  = '{0, 'h040, 1'b1, 4'h5, 32'h11223344, 1'b0, 1'b1, 32'hAA22CC44};
        vt[4]  = '{0, 'h040, 1'b0, 4'hF, 32'h0,        1'b0, 1'b1, 32'hAA22CC44};
        vt[5]  = '{1, 'h043, 1'b0, 4'h0, 32'h0,        1'b0, 1'b1, 32'hAA22CC44};
        vt[6]  = '{1, 'hF9C, 1'b1, 4'hF, 32'h12345678, 1'b0, 1'b1, 32'h12345678};
        vt[7]  = '{0, 'hFA0, 1'b1, 4'hF, 32'hBAD0BAD0, 1'b1, 1'b0, 32'h0};
        vt[8]  = '{0, 'hFA1, 1'b0, 4'hF, 32'h0,        1'b1, 1'b0, 32'h0};
        vt[9]  = '{1, 'hF9C, 1'b0, 4'hF, 32'h0,        1'b0, 1'b1, 32'h12345678};
        vt[10] = '{0, 'h010, 1'b1, 4'h0, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
        vt[11] = '{1, 'h010, 1'b0, 4'hF, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
        vt[12] = '{1, 'hFFC, 1'b0, 4'hF, 32'h0,        1'b1, 1'b0, 32'h0};

        // Reset state.
        rst = 1'b1;
        tick();
        tick();
        chk("reset a_ack", {63'd0, a_ack_o}, 64'd0);
        chk("reset a_err", {63'd0, a_err_o}, 64'd0);
        chk("reset a_dat", {32'd0, a_dat_o}, 64'd0);
        chk("reset b_ack", {63'd0, b_ack_o}, 64'd0);
        chk("reset b_err", {63'd0, b_err_o}, 64'd0);
        chk("reset b_dat", {32'd0, b_dat_o}, 64'd0);
        rst = 1'b0;
        tick();

        // Classic accesses from the vector table.
        for (int i = 0; i < 13; i++) classic(vt[i]);

        // No acceptance while err_o is high.
        drive(0, 'hFA0, 1'b0, 4'hF, 32'h0, 3'b000);
        push_exp(0, 1'b1, 1'b0, '0);
        tick();
        drive(0, 'h010, 1'b0, 4'hF, 32'h0, 3'b000);
        tick();
        chk("blocked after err", {63'd0, a_ack_o}, 64'd0);
        push_exp(0, 1'b0, 1'b1, 32'hDEADBEEF);
        tick();
        idle(0);
        tick();

        // Bursts.
        burst(1, 8, 1'b1, 4, -1, 32'd1);
        burst(0, 8, 1'b0, 4, -1, 32'd0);
        burst(1, 998, 1'b1, 4, 2, 32'hE0);
        burst(0, 998, 1'b0, 2, -1, 32'd0);

        // Write/write collision on word 5.
        classic('{0, 'h014, 1'b1, 4'hF, 32'h12345678, 1'b0, 1'b1, 32'h12345678});
        drive(0, 'h014, 1'b1, 4'b0001, 32'h000000FF, 3'b000);
        drive(1, 'h014, 1'b1, 4'b0011, 32'h0000FF00, 3'b000);
        push_exp(0, 1'b0, 1'b1, 32'h123456FF);
        push_exp(1, 1'b0, 1'b1, 32'h1234FF00);
        tick();
        idle(0);
        idle(1);
        tick();
        classic('{0, 'h014, 1'b0, 4'hF, 32'h0, 1'b0, 1'b1, 32'h1234FFFF});

        // Read/write collision on word 6: reader sees old contents.
        classic('{0, 'h018, 1'b1, 4'hF, 32'hCAFEF00D, 1'b0, 1'b1, 32'hCAFEF00D});
        drive(0, 'h018, 1'b0, 4'hF, 32'h0, 3'b000);
        drive(1, 'h018, 1'b1, 4'hF, 32'h0BADBEEF, 3'b000);
        push_exp(0, 1'b0, 1'b1, 32'hCAFEF00D);
        push_exp(1, 1'b0, 1'b1, 32'h0BADBEEF);
        tick();
        idle(0);
        idle(1);
        tick();
        classic('{0, 'h018, 1'b0, 4'hF, 32'h0, 1'b0, 1'b1, 32'h0BADBEEF});

        // Reset during beat 2 of a write burst.
        burst(1, 20, 1'b1, 4, -1, 32'h55550000);
        drive(1, 20 * 4, 1'b1, 4'hF, 32'hA0, 3'b010);
        push_exp(1, 1'b0, 1'b1, 32'hA0);
        model[20] = 32'hA0;
        tick();
        push_exp(1, 1'b0, 1'b0, '0);
        tick();
        drive(1, 21 * 4, 1'b1, 4'hF, 32'hA1, 3'b010);
        model[21] = 32'hA1;
        push_exp(1, 1'b0, 1'b0, '0);
        tick();
        drive(1, 22 * 4, 1'b1, 4'hF, 32'hA2, 3'b010);
        rst = 1'b1;
        tick();
        chk("rst burst b_ack", {63'd0, b_ack_o}, 64'd0);
        chk("rst burst b_err", {63'd0, b_err_o}, 64'd0);
        chk("rst burst b_dat", {32'd0, b_dat_o}, 64'd0);
        rst = 1'b0;
        idle(1);
        tick();
        burst(0, 20, 1'b0, 4, -1, 32'd0);

        chk("scoreboard A drained", 64'(q0.size()), 64'd0);
        chk("scoreboard B drained", 64'(q1.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
